// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d convolution cores.
//   pad_mode_t   : causal (zero-prefilled window) or valid (wait for a full window)
//   conv_state_t : IDLE / COMPUTE / FINISH states of the core FSM
//   clog2()      : ceiling log2 usable in parameter expressions
//   sat_trunc()  : fixed-point rescale, bias add and saturation to a DW-bit signed range
package cnn1d_pkg;

    typedef enum logic {
        PAD_CAUSAL = 1'b0,
        PAD_VALID  = 1'b1
    } pad_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } conv_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Drops FRACTION bits of the product format, adds the bias (already in the
    // data format) and clamps to [-2^(dw-1), 2^(dw-1)-1]. Works on 64-bit
    // values so one helper serves every core width; callers truncate to dw.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] acc,
        input int                 frac,
        input logic signed [63:0] bias,
        input int                 dw
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (acc >>> frac) + bias;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (dw - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1d_par_mac_lanes.sv
// Combinational multiply/accumulate slice for conv1d_par.
// Each call covers one beat: lane l multiplies tap (beat*NUM_MULTS + l) of the
// window by the matching weight; taps past the end of the filter contribute 0.
// Ports:
//   window  in  FILTER_SIZE x DATA_WIDTH   sample window, [0] newest
//   weights in  FILTER_SIZE x DATA_WIDTH   filter taps, [0] applies to newest
//   beat    in  BEAT_W                     current beat index
//   sum     out ACC_W (signed)             sum of the lane products for this beat
module conv1d_par_mac_lanes
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_MULTS   = 1,
    parameter int BEATS       = 5,
    parameter int BEAT_W      = 3,
    parameter int ACC_W       = 27
) (
    input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] window,
    input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] weights,
    input  logic [BEAT_W-1:0]                      beat,
    output logic signed [ACC_W-1:0]                sum
);

    // Operands are padded out to a whole number of beats so the last beat's
    // unused lanes see zero instead of needing a separate guard.
    localparam int TOT   = BEATS * NUM_MULTS;
    localparam int IDX_W = (clog2(TOT) < 1) ? 1 : clog2(TOT);

    logic [TOT-1:0][DATA_WIDTH-1:0] win_pad;
    logic [TOT-1:0][DATA_WIDTH-1:0] wgt_pad;
    logic [IDX_W-1:0]               idx;
    logic signed [2*DATA_WIDTH-1:0] prod [NUM_MULTS];

    always_comb begin
        win_pad = '0;
        wgt_pad = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            win_pad[k] = window[k];
            wgt_pad[k] = weights[k];
        end
    end

    always_comb begin
        idx = '0;
        sum = '0;
        for (int l = 0; l < NUM_MULTS; l++) begin
            idx     = IDX_W'(beat) * IDX_W'(NUM_MULTS) + IDX_W'(l);
            prod[l] = $signed(win_pad[idx]) * $signed(wgt_pad[idx]);
            sum     = sum + ACC_W'(prod[l]);
        end
    end

endmodule

// File: rtl/conv1d_par.sv
// 1-D convolution core with NUM_MULTS parallel MAC lanes, configurable stride,
// causal/valid padding, saturating signed output, optional ReLU and a
// synchronous clear for sequence boundaries.
// Ports:
//   clk, rst (async, active low)
//   conv1d_clear_in            sync clear of window and counters
//   conv1d_ready_in  / conv1d_valid_in / conv1d_data_in    sample input stream
//   conv1d_weights, conv1d_bias                            static coefficients
//   conv1d_ready_out / conv1d_valid_out / conv1d_data_out  result stream
//   conv1d_state_dbg           current FSM state
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds valid and data stable until that edge; ready may
// depend combinationally on state but never on the same-side valid.
module conv1d_par
    import cnn1d_pkg::*;
#(
    parameter int        DATA_WIDTH  = 12,
    parameter int        FRACTION    = 0,
    parameter int        FILTER_SIZE = 5,
    parameter int        NUM_MULTS   = 1,
    parameter int        STRIDE      = 1,
    parameter pad_mode_t PAD_MODE    = PAD_CAUSAL,
    parameter int        RELU_EN     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   conv1d_clear_in,
    output logic                                   conv1d_ready_in,
    input  logic                                   conv1d_valid_in,
    input  logic [DATA_WIDTH-1:0]                  conv1d_data_in,
    input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] conv1d_weights,
    input  logic [DATA_WIDTH-1:0]                  conv1d_bias,
    input  logic                                   conv1d_ready_out,
    output logic                                   conv1d_valid_out,
    output logic [DATA_WIDTH-1:0]                  conv1d_data_out,
    output conv_state_t                            conv1d_state_dbg
);

    localparam int BEATS  = (FILTER_SIZE + NUM_MULTS - 1) / NUM_MULTS;
    localparam int ACC_W  = 2 * DATA_WIDTH + clog2(FILTER_SIZE);
    localparam int BEAT_W = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
    localparam int FILL_W = (clog2(FILTER_SIZE) < 1) ? 1 : clog2(FILTER_SIZE);
    localparam int STR_W  = (clog2(STRIDE) < 1) ? 1 : clog2(STRIDE);

    conv_state_t                            state_q, state_d;
    logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [FILL_W-1:0]                      fill_q, fill_d;
    logic [STR_W-1:0]                       stride_q, stride_d;
    logic [BEAT_W-1:0]                      beat_q, beat_d;
    logic signed [ACC_W-1:0]                acc_q, acc_d;
    logic                                   valid_out_q, valid_out_d;
    logic [DATA_WIDTH-1:0]                  data_out_q, data_out_d;

    logic                    accept;
    logic                    eligible;
    logic signed [ACC_W-1:0] lane_sum;
    logic [DATA_WIDTH-1:0]   result;

    conv1d_par_mac_lanes #(
        .DATA_WIDTH (DATA_WIDTH),
        .FILTER_SIZE(FILTER_SIZE),
        .NUM_MULTS  (NUM_MULTS),
        .BEATS      (BEATS),
        .BEAT_W     (BEAT_W),
        .ACC_W      (ACC_W)
    ) u_mac_lanes (
        .window (win_q),
        .weights(conv1d_weights),
        .beat   (beat_q),
        .sum    (lane_sum)
    );

    // rst is folded in so the input port reads not-ready while reset is held.
    assign conv1d_ready_in  = rst && (state_q == IDLE) && !conv1d_clear_in;
    assign accept           = conv1d_valid_in && conv1d_ready_in;
    assign eligible         = (PAD_MODE == PAD_CAUSAL) ||
                              (fill_q >= FILL_W'(FILTER_SIZE - 1));
    assign conv1d_valid_out = valid_out_q;
    assign conv1d_data_out  = data_out_q;
    assign conv1d_state_dbg = state_q;

    // Final result from the finished accumulator.
    always_comb begin
        result = DATA_WIDTH'(sat_trunc(64'(acc_q), FRACTION,
                                       64'($signed(conv1d_bias)), DATA_WIDTH));
        if ((RELU_EN != 0) && result[DATA_WIDTH-1]) begin
            result = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        fill_d      = fill_q;
        stride_d    = stride_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;

        // Output handshake; FINISH may reload in the same cycle below.
        if (valid_out_q && conv1d_ready_out) begin
            valid_out_d = 1'b0;
        end

        if (conv1d_clear_in) begin
            // Sequence boundary: drop any result in progress, keep the one
            // already presented on the output.
            state_d  = IDLE;
            win_d    = '0;
            fill_d   = '0;
            stride_d = '0;
            beat_d   = '0;
            acc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_d[0] = conv1d_data_in;
                        for (int k = 1; k < FILTER_SIZE; k++) begin
                            win_d[k] = win_q[k-1];
                        end
                        if (fill_q != FILL_W'(FILTER_SIZE - 1)) begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                        if (eligible) begin
                            if (stride_q == '0) begin
                                state_d = COMPUTE;
                                acc_d   = '0;
                                beat_d  = '0;
                            end
                            if (stride_q == STR_W'(STRIDE - 1)) begin
                                stride_d = '0;
                            end else begin
                                stride_d = stride_q + STR_W'(1);
                            end
                        end
                    end
                end
                COMPUTE: begin
                    acc_d = acc_q + lane_sum;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = FINISH;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                FINISH: begin
                    if (!valid_out_q || conv1d_ready_out) begin
                        data_out_d  = result;
                        valid_out_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            fill_q      <= '0;
            stride_q    <= '0;
            beat_q      <= '0;
            acc_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            fill_q      <= fill_d;
            stride_q    <= stride_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

endmodule

// File: tb/tb_conv1d_par.sv
// Bench for conv1d_par: six instances cover causal, valid padding, stride 2,
// two and three lanes, and ReLU disabled. A sample-history model computes each
// expected result directly as a dot product of the last FILTER_SIZE samples.
module tb_conv1d_par;
    import cnn1d_pkg::*;

    localparam int NI = 6;
    localparam int FS = 3;
    localparam int NM_P [NI] = '{1, 1, 1, 2, 3, 1};
    localparam int ST_P [NI] = '{1, 1, 2, 1, 1, 1};
    localparam int PV_P [NI] = '{0, 1, 0, 0, 0, 0};
    localparam int RL_P [NI] = '{1, 1, 1, 1, 1, 0};

    logic              clk;
    logic              rst_n;
    logic              clear_in  [NI];
    logic              valid_in  [NI];
    logic [11:0]       data_in   [NI];
    logic [2:0][11:0]  weights   [NI];
    logic [11:0]       bias      [NI];
    logic              ready_out [NI];
    logic              ready_in  [NI];
    logic              valid_out [NI];
    logic [11:0]       data_out  [NI];
    conv_state_t       state_dbg [NI];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_hist[$];
    int          m_elig;
    logic [11:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        conv1d_par #(
            .DATA_WIDTH (12),
            .FRACTION   (0),
            .FILTER_SIZE(FS),
            .NUM_MULTS  (NM_P[g]),
            .STRIDE     (ST_P[g]),
            .PAD_MODE   ((PV_P[g] != 0) ? PAD_VALID : PAD_CAUSAL),
            .RELU_EN    (RL_P[g])
        ) u_dut (
            .clk             (clk),
            .rst             (rst_n),
            .conv1d_clear_in (clear_in[g]),
            .conv1d_ready_in (ready_in[g]),
            .conv1d_valid_in (valid_in[g]),
            .conv1d_data_in  (data_in[g]),
            .conv1d_weights  (weights[g]),
            .conv1d_bias     (bias[g]),
            .conv1d_ready_out(ready_out[g]),
            .conv1d_valid_out(valid_out[g]),
            .conv1d_data_out (data_out[g]),
            .conv1d_state_dbg(state_dbg[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int beats_of(input int i);
        return (FS + NM_P[i] - 1) / NM_P[i];
    endfunction

    function automatic void model_clear();
        m_hist.delete();
        m_elig = 0;
    endfunction

    function automatic logic [11:0] model_result(input int i);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < FS; k++) begin
            if (k < m_hist.size()) begin
                acc += longint'($signed(weights[i][k])) * longint'(m_hist[k]);
            end
        end
        r = acc + longint'($signed(bias[i]));
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        if (RL_P[i] != 0 && r < 0) r = 0;
        return 12'(r);
    endfunction

    // Returns whether this accepted sample should produce an output.
    function automatic bit model_accept(input int i, input int s);
        int  n_before;
        bit  elig;
        bit  has;
        n_before = m_hist.size();
        m_hist.push_front(s);
        if (m_hist.size() > FS) void'(m_hist.pop_back());
        elig = (PV_P[i] == 0) || (n_before >= FS - 1);
        has  = 1'b0;
        if (elig) begin
            if (m_elig % ST_P[i] == 0) begin
                has = 1'b1;
                exp_q.push_back(model_result(i));
            end
            m_elig++;
        end
        return has;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_coef(input int i, input int w0, input int w1, input int w2, input int b);
        weights[i][0] = 12'(w0);
        weights[i][1] = 12'(w1);
        weights[i][2] = 12'(w2);
        bias[i]       = 12'(b);
    endtask

    task automatic do_clear(input int i);
        @(negedge clk);
        clear_in[i] = 1'b1;
        @(negedge clk);
        clear_in[i] = 1'b0;
        model_clear();
        exp_q.delete();
    endtask

    task automatic send_only(input int i, input int s, output bit has);
        int cnt;
        @(negedge clk);
        valid_in[i] = 1'b1;
        data_in[i]  = 12'(s);
        cnt = 0;
        while (!ready_in[i] && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt >= 64) begin
            failures++;
            $display("FAIL accept_timeout inst=%0d ready_in=%0b required=1", i, ready_in[i]);
        end
        @(posedge clk);
        #1;
        valid_in[i] = 1'b0;
        has = model_accept(i, s);
    endtask

    task automatic drive_and_check(input int i, input int s, input string name);
        bit          has;
        int          cyc;
        logic [11:0] e;
        send_only(i, s, has);
        if (has) begin
            e   = exp_q.pop_front();
            cyc = 0;
            do begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end while (!valid_out[i] && cyc < 64);
            checks++;
            if (cyc != beats_of(i) + 1) begin
                failures++;
                $display("FAIL %s_latency inst=%0d got=%0d required=%0d", name, i, cyc, beats_of(i) + 1);
            end
            checks++;
            if (data_out[i] !== e) begin
                failures++;
                $display("FAIL %s_data inst=%0d sample=%0d got=%0d required=%0d",
                         name, i, s, $signed(data_out[i]), $signed(e));
            end
        end else begin
            @(negedge clk);
            checks++;
            if (valid_out[i] !== 1'b0 || ready_in[i] !== 1'b1) begin
                failures++;
                $display("FAIL %s_no_output inst=%0d valid_out=%0b ready_in=%0b required=0/1",
                         name, i, valid_out[i], ready_in[i]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            clear_in[i]  = 1'b0;
            valid_in[i]  = 1'b0;
            data_in[i]   = '0;
            ready_out[i] = 1'b1;
            set_coef(i, 1, 2, 3, 0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ready_in[i] !== 1'b0 || valid_out[i] !== 1'b0 || data_out[i] !== 12'd0) begin
                failures++;
                $display("FAIL reset_hold inst=%0d ready_in=%0b valid_out=%0b data_out=%0d required=0/0/0",
                         i, ready_in[i], valid_out[i], data_out[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ready_in[i] !== 1'b1 || state_dbg[i] !== IDLE) begin
                failures++;
                $display("FAIL reset_release inst=%0d ready_in=%0b state=%0d required=1/IDLE",
                         i, ready_in[i], state_dbg[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_causal();
        set_coef(0, 1, 2, 3, 0);
        do_clear(0);
        for (int s = 1; s <= 4; s++) drive_and_check(0, s, "causal");
    endtask

    task automatic test_valid_pad();
        set_coef(1, 1, 2, 3, 0);
        do_clear(1);
        for (int s = 1; s <= 4; s++) drive_and_check(1, s, "valid_pad");
    endtask

    task automatic test_stride();
        set_coef(2, 1, 2, 3, 0);
        do_clear(2);
        for (int s = 1; s <= 4; s++) drive_and_check(2, s, "stride");
    endtask

    task automatic test_lanes();
        for (int i = 3; i <= 4; i++) begin
            set_coef(i, 1, 2, 3, 0);
            do_clear(i);
            for (int s = 1; s <= 4; s++) drive_and_check(i, s, "lanes");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < NI; i++) begin
            if ($urandom_range(0, 1) == 1)
                set_coef(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            else
                set_coef(i, int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30,
                         int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 400)) - 200);
            do_clear(i);
            for (int n = 0; n < 7; n++) begin
                int s;
                s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) - 2048
                                                : int'($urandom_range(0, 200)) - 100;
                drive_and_check(i, s, "random");
            end
        end
    endtask

    task automatic test_saturation();
        set_coef(0, 2047, 2047, 2047, 0);
        do_clear(0);
        drive_and_check(0, 2047, "sat_pos");
        set_coef(5, -2047, -2047, -2047, 0);
        do_clear(5);
        drive_and_check(5, 2047, "sat_neg");
        set_coef(0, -2047, -2047, -2047, 0);
        do_clear(0);
        drive_and_check(0, 2047, "sat_relu");
    endtask

    task automatic test_backpressure();
        bit          has;
        int          cnt;
        logic [11:0] e_a;
        logic [11:0] e_b;
        set_coef(0, 1, 2, 3, 0);
        do_clear(0);
        ready_out[0] = 1'b0;
        send_only(0, 2, has);
        cnt = 0;
        while (!valid_out[0] && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        send_only(0, 3, has);
        e_a = exp_q.pop_front();
        e_b = exp_q.pop_front();
        cnt = 0;
        while (state_dbg[0] != FINISH && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt >= 64) begin
            failures++;
            $display("FAIL bp_reach_finish state=%0d required=FINISH", state_dbg[0]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (valid_out[0] !== 1'b1 || data_out[0] !== e_a ||
                state_dbg[0] !== FINISH || ready_in[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%0b data=%0d state=%0d ready_in=%0b required=1/%0d/FINISH/0",
                         c, valid_out[0], data_out[0], state_dbg[0], ready_in[0], e_a);
            end
        end
        ready_out[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_out[0] !== 1'b1 || data_out[0] !== e_b) begin
            failures++;
            $display("FAIL bp_reload valid=%0b data=%0d required=1/%0d", valid_out[0], data_out[0], e_b);
        end
        @(negedge clk);
        checks++;
        if (valid_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain valid=%0b required=0", valid_out[0]);
        end
    endtask

    task automatic test_clear();
        bit has;
        set_coef(0, 1, 2, 3, 0);
        do_clear(0);
        drive_and_check(0, 1, "clr_pre");
        drive_and_check(0, 2, "clr_pre");
        send_only(0, 3, has);
        @(negedge clk);
        checks++;
        if (state_dbg[0] !== COMPUTE) begin
            failures++;
            $display("FAIL clr_in_compute state=%0d required=COMPUTE", state_dbg[0]);
        end
        clear_in[0] = 1'b1;
        @(negedge clk);
        clear_in[0] = 1'b0;
        model_clear();
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (valid_out[0] !== 1'b0 || state_dbg[0] !== IDLE) begin
                failures++;
                $display("FAIL clr_abort cyc=%0d valid=%0b state=%0d required=0/IDLE",
                         c, valid_out[0], state_dbg[0]);
            end
        end
        // clear wins over a same-cycle input beat
        valid_in[0] = 1'b1;
        data_in[0]  = 12'd7;
        clear_in[0] = 1'b1;
        #1;
        checks++;
        if (ready_in[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_dominates ready_in=%0b required=0", ready_in[0]);
        end
        @(negedge clk);
        valid_in[0] = 1'b0;
        clear_in[0] = 1'b0;
        drive_and_check(0, 5, "clr_after");
    endtask

    task automatic test_reset_mid();
        bit has;
        set_coef(0, 1, 2, 3, 0);
        do_clear(0);
        drive_and_check(0, 6, "rst_pre");
        send_only(0, 4, has);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out[0] !== 1'b0 || data_out[0] !== 12'd0 ||
            ready_in[0] !== 1'b0 || state_dbg[0] !== IDLE) begin
            failures++;
            $display("FAIL rst_mid valid=%0b data=%0d ready_in=%0b state=%0d required=0/0/0/IDLE",
                     valid_out[0], data_out[0], ready_in[0], state_dbg[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        exp_q.delete();
        drive_and_check(0, 5, "rst_after");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_causal();
        test_valid_pad();
        test_stride();
        test_lanes();
        test_saturation();
        test_random();
        test_backpressure();
        test_clear();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required=completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
